id_pair_packer: RTL

ID_PAIR_PACKER -- requirements
Module: id_pair_packer

---
 rtl/id_pair_packer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/id_pair_packer.sv
// Packs 2*VEC_ID_WIDTH-bit ID pairs into BUS_WIDTH-bit AXI-Stream beats for DMA writeback.
// Optional macro ID_PAIR_PACKER_COUNT_EN enables the saturating accepted-pair counter on o_PairCount.
module id_pair_packer #(
    parameter int BUS_WIDTH    = 512,
    parameter int VEC_ID_WIDTH = 8
) (
    input  logic                      ap_clk,
    input  logic                      ap_rstn,
    input  logic [2*VEC_ID_WIDTH-1:0] S_AXIS_ID_PAIR_tdata,
    input  logic                      S_AXIS_ID_PAIR_tvalid,
    input  logic                      S_AXIS_ID_PAIR_tlast,
    output logic                      S_AXIS_ID_PAIR_tready,
    output logic [BUS_WIDTH-1:0]      M_AXIS_DATA_tdata,
    output logic [BUS_WIDTH/8-1:0]    M_AXIS_DATA_tkeep,
    output logic                      M_AXIS_DATA_tvalid,
    output logic                      M_AXIS_DATA_tlast,
    input  logic                      M_AXIS_DATA_tready,
    output logic [31:0]               o_PairCount
);
    localparam int PW             = 2 * VEC_ID_WIDTH;
    localparam int PAIRS_PER_BEAT = BUS_WIDTH / PW;
    localparam int KW             = BUS_WIDTH / 8;
    localparam int CW             = (PAIRS_PER_BEAT > 1) ? $clog2(PAIRS_PER_BEAT) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PAIRS_PER_BEAT - 1);

    typedef enum logic [0:0] {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

    // Byte enables covering the low n pairs of a beat.
    function automatic logic [KW-1:0] keep_for(input logic [CW:0] n);
        logic [KW-1:0] k;
        k = '0;
        for (int b = 0; b < KW; b++) begin
            k[b] = ((b * 8) < (int'(n) * PW));
        end
        return k;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BUS_WIDTH-1:0]   r_acc;
    logic [KW-1:0]          r_acc_keep;
    logic                   r_acc_last;
    logic [CW-1:0]          r_fill;
    logic                   r_s_ready;
    logic                   r_m_valid;
    logic [BUS_WIDTH-1:0]   r_m_data;
    logic [KW-1:0]          r_m_keep;
    logic                   r_m_last;

    logic                   w_accept;
    logic                   w_close;
    logic                   w_out_free;
    logic [BUS_WIDTH-1:0]   w_pair_ext;
    logic [BUS_WIDTH-1:0]   w_beat_data;
    logic [KW-1:0]          w_beat_keep;
    logic                   w_load_new;
    logic                   w_load_acc;
    logic                   w_hold_beat;
    logic                   w_add_pair;

    assign w_accept    = S_AXIS_ID_PAIR_tvalid & r_s_ready;
    assign w_close     = w_accept & ((r_fill == LAST_SLOT) | S_AXIS_ID_PAIR_tlast);
    assign w_out_free  = ~r_m_valid | M_AXIS_DATA_tready;
    assign w_pair_ext  = {{(BUS_WIDTH-PW){1'b0}}, S_AXIS_ID_PAIR_tdata};
    assign w_beat_data = r_acc | (w_pair_ext << (int'(r_fill) * PW));
    assign w_beat_keep = keep_for({1'b0, r_fill} + {{CW{1'b0}}, 1'b1});

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_acc  = 1'b0;
        w_hold_beat = 1'b0;
        w_add_pair  = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_close) begin
                    if (w_out_free) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_hold_beat = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (w_accept) begin
                    w_add_pair = 1'b1;
                end else begin
                    w_add_pair = 1'b0;
                end
            end
            ST_HOLD: begin
                if (w_out_free) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = ST_FILL;
                end else begin
                    w_load_acc = 1'b0;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // State register and registered input ready.
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == ST_FILL);
        end
    end

    // Accumulator; in HOLD it keeps the closed beat with its keep/last.
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_fill     <= '0;
        end else if (w_load_new || w_load_acc) begin
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_fill     <= '0;
        end else if (w_hold_beat) begin
            r_acc      <= w_beat_data;
            r_acc_keep <= w_beat_keep;
            r_acc_last <= S_AXIS_ID_PAIR_tlast;
        end else if (w_add_pair) begin
            r_acc  <= w_beat_data;
            r_fill <= r_fill + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Output beat register.
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_load_new) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_beat_data;
            r_m_keep  <= w_beat_keep;
            r_m_last  <= S_AXIS_ID_PAIR_tlast;
        end else if (w_load_acc) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_acc;
            r_m_keep  <= r_acc_keep;
            r_m_last  <= r_acc_last;
        end else if (M_AXIS_DATA_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign S_AXIS_ID_PAIR_tready = r_s_ready;
    assign M_AXIS_DATA_tvalid    = r_m_valid;
    assign M_AXIS_DATA_tdata     = r_m_data;
    assign M_AXIS_DATA_tkeep     = r_m_keep;
    assign M_AXIS_DATA_tlast     = r_m_last;

`ifdef ID_PAIR_PACKER_COUNT_EN
    logic [31:0] r_count;

    // Saturating count of accepted input pairs.
    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            r_count <= 32'd0;
        end else if (w_accept && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_PairCount = r_count;
`else
    assign o_PairCount = 32'd0;
`endif

endmodule
